ifq_param: RTL and testbench

Parametrised instruction fetch queue between the instruction cache and the decode stage. It issues line requests to the cache and buffers up to DEPTH returned lines of WORDS 32-bit instructions. It presents one instruction per cycle to decode with its PC, and redirects on jump/branch. Relative to the fixed 4x4 queue, it adds:

- configurable line width and depth;
- tracking of one outstanding cache request, with discard of stale responses after a redirect;
- byte-accurate PC (+4 per instruction);
- an optional empty-queue bypass.

---
 rtl/ifq_param_if.sv | 30 +++
 rtl/ifq_param.sv | 142 ++++++++++++++
 tb/tb_ifq_param.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ifq_param_if.sv
// Fetch-queue bus: cache request/response, redirect and decode-side signals.
// The queue itself uses the master modport; the surrounding fetch logic uses slave.
interface ifq_param_if #(
  parameter int unsigned WORDS = 4,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LD = $clog2(DEPTH);

  logic [32*WORDS-1:0] Dout;
  logic                Dout_valid;
  logic                Rd_en;
  logic [31:0]         Jmp_branch_address;
  logic                Jmp_branch_valid;
  logic [31:0]         Pc_in;
  logic                Rd_en_cache;
  logic [31:0]         Pc_out;
  logic [31:0]         Inst;
  logic                Empty;
  logic [LD:0]         Lines_used;

  modport master (
    input  Dout, Dout_valid, Rd_en, Jmp_branch_address, Jmp_branch_valid,
    output Pc_in, Rd_en_cache, Pc_out, Inst, Empty, Lines_used
  );

  modport slave (
    output Dout, Dout_valid, Rd_en, Jmp_branch_address, Jmp_branch_valid,
    input  Pc_in, Rd_en_cache, Pc_out, Inst, Empty, Lines_used
  );
endinterface

// File: rtl/ifq_param.sv
// Parametrised instruction fetch queue: one outstanding cache line request,
// DEPTH buffered lines of WORDS instructions, one instruction per cycle to decode,
// redirect with stale-response discard, optional empty-queue bypass.
module ifq_param #(
  parameter int unsigned WORDS  = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned BYPASS = 1
) (
  input logic         clk,
  input logic         reset,
  ifq_param_if.master bus
);
  localparam int unsigned LW         = $clog2(WORDS);
  localparam int unsigned LD         = $clog2(DEPTH);
  localparam logic [31:0] LINE_BYTES = 32'(WORDS * 4);
  localparam logic [LD:0] DEPTH_CNT  = (LD+1)'(DEPTH);
  localparam logic [LW-1:0] LAST_WORD = LW'(WORDS - 1);

  typedef logic [WORDS-1:0][31:0] line_t;

  line_t         mem_q [DEPTH];
  line_t         mem_d [DEPTH];
  logic [LD:0]   wp_q, wp_d;
  logic [LD:0]   rp_line_q, rp_line_d;
  logic [LW-1:0] rp_word_q, rp_word_d;
  logic          pending_q, pending_d;
  logic          drop_q, drop_d;
  logic [31:0]   pc_in_q, pc_in_d;
  logic [31:0]   pc_out_q, pc_out_d;

  line_t         dout_line;
  logic [LD:0]   lines_used;
  logic          q_empty;
  logic          req;
  logic          resp_acc;
  logic          resp_wr;
  logic          byp;
  logic          empty;
  logic          pop;
  logic [31:0]   inst;

  // Occupancy, request/response qualification, bypass and read-port selection
  always_comb begin
    dout_line  = bus.Dout;
    lines_used = wp_q - rp_line_q;
    q_empty    = (lines_used == '0);
    req        = reset && !bus.Jmp_branch_valid && !pending_q &&
                 ((lines_used + (LD+1)'(pending_q)) < DEPTH_CNT);
    resp_acc   = bus.Dout_valid && pending_q && !bus.Jmp_branch_valid;
    resp_wr    = resp_acc && !drop_q;
    byp        = (BYPASS != 0) && q_empty && resp_wr;
    empty      = q_empty && !byp;
    pop        = bus.Rd_en && !empty && !bus.Jmp_branch_valid;
    inst       = '0;
    if (byp) begin
      inst = dout_line[rp_word_q];
    end else if (!q_empty) begin
      inst = mem_q[rp_line_q[LD-1:0]][rp_word_q];
    end
  end

  // Next-state: a redirect overrides every other event in its cycle
  always_comb begin
    mem_d     = mem_q;
    wp_d      = wp_q;
    rp_line_d = rp_line_q;
    rp_word_d = rp_word_q;
    pending_d = pending_q;
    drop_d    = drop_q;
    pc_in_d   = pc_in_q;
    pc_out_d  = pc_out_q;
    if (bus.Jmp_branch_valid) begin
      pc_in_d   = bus.Jmp_branch_address & ~(LINE_BYTES - 32'd1);
      pc_out_d  = {bus.Jmp_branch_address[31:2], 2'b00};
      rp_word_d = bus.Jmp_branch_address[LW+1:2];
      wp_d      = '0;
      rp_line_d = '0;
      // A response landing with the redirect retires the request outright;
      // otherwise the one still in flight is marked for discard.
      if (pending_q && bus.Dout_valid) begin
        pending_d = 1'b0;
        drop_d    = 1'b0;
      end else if (pending_q) begin
        drop_d = 1'b1;
      end
    end else begin
      if (req) begin
        pending_d = 1'b1;
        pc_in_d   = pc_in_q + LINE_BYTES;
      end
      if (resp_acc) begin
        pending_d = 1'b0;
        if (drop_q) begin
          drop_d = 1'b0;
        end else begin
          mem_d[wp_q[LD-1:0]] = dout_line;
          wp_d                = wp_q + (LD+1)'(1);
        end
      end
      if (pop) begin
        pc_out_d  = pc_out_q + 32'd4;
        rp_word_d = rp_word_q + LW'(1);
        if (rp_word_q == LAST_WORD) begin
          rp_line_d = rp_line_q + (LD+1)'(1);
        end
      end
    end
  end

  // Line storage: no reset, only entries between rp_line and wp are ever read
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q      <= '0;
      rp_line_q <= '0;
      rp_word_q <= '0;
      pending_q <= 1'b0;
      drop_q    <= 1'b0;
      pc_in_q   <= '0;
      pc_out_q  <= '0;
    end else begin
      wp_q      <= wp_d;
      rp_line_q <= rp_line_d;
      rp_word_q <= rp_word_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      pc_in_q   <= pc_in_d;
      pc_out_q  <= pc_out_d;
    end
  end

  assign bus.Pc_in       = pc_in_q;
  assign bus.Rd_en_cache = req;
  assign bus.Pc_out      = pc_out_q;
  assign bus.Inst        = inst;
  assign bus.Empty       = empty;
  assign bus.Lines_used  = lines_used;
endmodule

// File: tb/tb_ifq_param.sv
// Bench for ifq_param: a cache responder plus an in-order instruction-stream
// model (expected PC and request address sequences) checked every cycle.
module tb_ifq_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ifq_param_if #(.WORDS(4), .DEPTH(4)) ifa ();
  ifq_param_if #(.WORDS(4), .DEPTH(4)) ifb ();
  ifq_param_if #(.WORDS(8), .DEPTH(2)) ifc ();

  ifq_param #(.WORDS(4), .DEPTH(4), .BYPASS(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa.master));
  ifq_param #(.WORDS(4), .DEPTH(4), .BYPASS(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb.master));
  ifq_param #(.WORDS(8), .DEPTH(2), .BYPASS(1)) dut_c (.clk(clk), .reset(reset), .bus(ifc.master));

  // The non-bypass queue sees exactly the stimulus of the bypass one
  assign ifb.Dout               = ifa.Dout;
  assign ifb.Dout_valid         = ifa.Dout_valid;
  assign ifb.Rd_en              = ifa.Rd_en;
  assign ifb.Jmp_branch_address = ifa.Jmp_branch_address;
  assign ifb.Jmp_branch_valid   = ifa.Jmp_branch_valid;

  int nvec = 0, nerr = 0, npop = 0, nreq = 0, ccnt = 0, lat = 0;
  logic cbusy = 1'b0, inject = 1'b0;
  logic [31:0] caddr, exp_pc, exp_req;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return (pc >> 2) + 32'h1000;
  endfunction

  function automatic logic [127:0] line4(input logic [31:0] a);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = inst_of(a + 32'(4*i));
    return l;
  endfunction

  function automatic logic [255:0] line8(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = inst_of(a + 32'(4*i));
    return l;
  endfunction

  task automatic idle_inputs();
    ifa.Dout = '0; ifa.Dout_valid = 1'b0; ifa.Rd_en = 1'b0;
    ifa.Jmp_branch_valid = 1'b0; ifa.Jmp_branch_address = '0;
    ifc.Dout = '0; ifc.Dout_valid = 1'b0; ifc.Rd_en = 1'b0;
    ifc.Jmp_branch_valid = 1'b0; ifc.Jmp_branch_address = '0;
  endtask

  task automatic assert_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    reset = 1'b1; cbusy = 1'b0; inject = 1'b0;
    exp_pc = 32'd0; exp_req = 32'd0;
  endtask

  // One cycle on queue A: cache drives, inputs applied, outputs checked against the stream model
  task automatic cyc(input logic rd, input logic jv, input logic [31:0] ja);
    logic pop;
    @(negedge clk);
    ifa.Dout = {$urandom, $urandom, $urandom, $urandom};
    ifa.Dout_valid = 1'b0;
    if (cbusy && ccnt == 0) begin
      ifa.Dout_valid = 1'b1; ifa.Dout = line4(caddr); cbusy = 1'b0;
    end else begin
      if (cbusy) ccnt--;
      if (inject) begin ifa.Dout_valid = 1'b1; ifa.Dout = line4(32'h500); end
    end
    ifa.Rd_en = rd; ifa.Jmp_branch_valid = jv; ifa.Jmp_branch_address = ja;
    #1;
    nvec++;
    if (ifa.Lines_used > 3'd4) begin nerr++; $display("FAIL lines_used_bound: got %0d max 4", ifa.Lines_used); end
    if (ifa.Empty) begin
      nvec++;
      if (ifa.Inst !== 32'd0) begin nerr++; $display("FAIL inst_when_empty: got %h expected 0", ifa.Inst); end
    end else begin
      nvec++;
      if (ifa.Pc_out !== exp_pc) begin nerr++; $display("FAIL pc_out: got %h expected %h", ifa.Pc_out, exp_pc); end
      nvec++;
      if (ifa.Inst !== inst_of(exp_pc)) begin nerr++; $display("FAIL inst: got %h expected %h", ifa.Inst, inst_of(exp_pc)); end
    end
    pop = rd && !ifa.Empty && !jv;
    if (pop) begin exp_pc = exp_pc + 32'd4; npop++; end
    if (ifa.Rd_en_cache) begin
      nvec++;
      if (jv || ifa.Pc_in !== exp_req) begin
        nerr++; $display("FAIL request: got Pc_in %h jump %b expected %h no jump", ifa.Pc_in, jv, exp_req);
      end
      exp_req = exp_req + 32'd16;
      cbusy = 1'b1; caddr = ifa.Pc_in; ccnt = lat; nreq++;
    end
    if (jv) begin exp_pc = {ja[31:2], 2'b00}; exp_req = {ja[31:4], 4'b0000}; end
  endtask

  task automatic test_reset();
    assert_reset();
    nvec++; if (ifa.Pc_in !== 32'd0) begin nerr++; $display("FAIL reset_pc_in: got %h expected 0", ifa.Pc_in); end
    nvec++; if (ifa.Pc_out !== 32'd0) begin nerr++; $display("FAIL reset_pc_out: got %h expected 0", ifa.Pc_out); end
    nvec++; if (ifa.Empty !== 1'b1) begin nerr++; $display("FAIL reset_empty: got %b expected 1", ifa.Empty); end
    nvec++; if (ifa.Inst !== 32'd0) begin nerr++; $display("FAIL reset_inst: got %h expected 0", ifa.Inst); end
    nvec++; if (ifa.Lines_used !== 3'd0) begin nerr++; $display("FAIL reset_lines: got %0d expected 0", ifa.Lines_used); end
    nvec++; if (ifa.Rd_en_cache !== 1'b0) begin nerr++; $display("FAIL reset_req: got %b expected 0", ifa.Rd_en_cache); end
    release_reset();
  endtask

  task automatic test_stream();
    int p0;
    assert_reset(); release_reset();
    lat = 0; p0 = npop;
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 32'd0);
    nvec++;
    if (npop - p0 != 29) begin nerr++; $display("FAIL stream_throughput: got %0d pops expected 29", npop - p0); end
  endtask

  task automatic test_full();
    int r0;
    assert_reset(); release_reset();
    lat = 0; r0 = nreq;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 32'd0);
    nvec++; if (nreq - r0 != 4) begin nerr++; $display("FAIL full_requests: got %0d expected 4", nreq - r0); end
    nvec++; if (ifa.Lines_used !== 3'd4) begin nerr++; $display("FAIL full_lines: got %0d expected 4", ifa.Lines_used); end
    r0 = nreq;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'd0);
    nvec++; if (nreq != r0) begin nerr++; $display("FAIL full_hold: got %0d requests expected 0", nreq - r0); end
    cyc(1'b0, 1'b0, 32'd0);
    nvec++; if (ifa.Rd_en_cache !== 1'b1) begin nerr++; $display("FAIL full_release: got %b expected 1", ifa.Rd_en_cache); end
  endtask

  task automatic test_jump_pending();
    int p0;
    assert_reset(); release_reset();
    lat = 3;
    cyc(1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 32'h108);
    lat = 0; p0 = npop;
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 32'd0);
    nvec++; if (npop - p0 < 4) begin nerr++; $display("FAIL jump_pending_progress: got %0d pops expected >=4", npop - p0); end
  endtask

  task automatic test_jump_resp();
    assert_reset(); release_reset();
    lat = 0;
    cyc(1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 32'h204C);
    nvec++; if (ifa.Empty !== 1'b1) begin nerr++; $display("FAIL jump_resp_empty: got %b expected 1", ifa.Empty); end
    cyc(1'b1, 1'b0, 32'd0);
    nvec++; if (ifa.Rd_en_cache !== 1'b1) begin nerr++; $display("FAIL jump_resp_req: got %b expected 1", ifa.Rd_en_cache); end
    nvec++; if (ifa.Pc_out !== 32'h204C) begin nerr++; $display("FAIL jump_resp_pc: got %h expected 204c", ifa.Pc_out); end
    nvec++; if (ifa.Lines_used !== 3'd0) begin nerr++; $display("FAIL jump_resp_lines: got %0d expected 0", ifa.Lines_used); end
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'd0);
  endtask

  task automatic test_bypass_latency();
    logic seen = 1'b0;
    assert_reset(); release_reset();
    lat = 2;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc(1'b0, 1'b0, 32'd0);
      seen = ifa.Dout_valid;
    end
    nvec++;
    if (!seen) begin nerr++; $display("FAIL bypass_timeout: got no response expected one"); end
    nvec++; if (ifa.Empty !== 1'b0) begin nerr++; $display("FAIL bypass_a_empty: got %b expected 0", ifa.Empty); end
    nvec++; if (ifb.Empty !== 1'b1) begin nerr++; $display("FAIL nobypass_same_cycle: got %b expected 1", ifb.Empty); end
    cyc(1'b0, 1'b0, 32'd0);
    nvec++; if (ifb.Empty !== 1'b0) begin nerr++; $display("FAIL nobypass_next_cycle: got %b expected 0", ifb.Empty); end
    nvec++; if (ifb.Inst !== inst_of(32'd0)) begin nerr++; $display("FAIL nobypass_inst: got %h expected %h", ifb.Inst, inst_of(32'd0)); end
    nvec++; if (ifb.Pc_out !== 32'd0) begin nerr++; $display("FAIL nobypass_pc: got %h expected 0", ifb.Pc_out); end
  endtask

  task automatic test_wrap();
    logic [31:0] cexp, creq, caddr8;
    logic cb = 1'b0;
    int pc_pops = 0;
    assert_reset(); release_reset();
    @(negedge clk);
    ifc.Rd_en = 1'b1; ifc.Jmp_branch_valid = 1'b1; ifc.Jmp_branch_address = 32'hFFFF_FFF0;
    #1;
    nvec++; if (ifc.Rd_en_cache !== 1'b0) begin nerr++; $display("FAIL wrap_jump_req: got %b expected 0", ifc.Rd_en_cache); end
    cexp = 32'hFFFF_FFF0; creq = 32'hFFFF_FFE0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      ifc.Jmp_branch_valid = 1'b0; ifc.Dout_valid = 1'b0; ifc.Dout = '0;
      if (cb) begin ifc.Dout_valid = 1'b1; ifc.Dout = line8(caddr8); cb = 1'b0; end
      #1;
      if (!ifc.Empty) begin
        nvec++; if (ifc.Pc_out !== cexp) begin nerr++; $display("FAIL wrap_pc: got %h expected %h", ifc.Pc_out, cexp); end
        nvec++; if (ifc.Inst !== inst_of(cexp)) begin nerr++; $display("FAIL wrap_inst: got %h expected %h", ifc.Inst, inst_of(cexp)); end
        cexp = cexp + 32'd4; pc_pops++;
      end
      if (ifc.Rd_en_cache) begin
        nvec++; if (ifc.Pc_in !== creq) begin nerr++; $display("FAIL wrap_req: got %h expected %h", ifc.Pc_in, creq); end
        creq = creq + 32'd32; cb = 1'b1; caddr8 = ifc.Pc_in;
      end
      nvec++; if (ifc.Lines_used > 2'd2) begin nerr++; $display("FAIL wrap_lines: got %0d max 2", ifc.Lines_used); end
    end
    nvec++; if (pc_pops < 12) begin nerr++; $display("FAIL wrap_progress: got %0d pops expected >=12", pc_pops); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int r0;
    assert_reset(); release_reset();
    lat = 0; r0 = nreq;
    for (int i = 0; i < 20 && nreq - r0 < 3; i++) cyc(1'b0, 1'b0, 32'd0);
    nvec++; if (ifa.Lines_used !== 3'd2) begin nerr++; $display("FAIL mid_lines_before: got %0d expected 2", ifa.Lines_used); end
    assert_reset();
    nvec++; if (ifa.Empty !== 1'b1 || ifa.Inst !== 32'd0) begin nerr++; $display("FAIL mid_reset_out: got empty %b inst %h expected 1 0", ifa.Empty, ifa.Inst); end
    nvec++; if (ifa.Lines_used !== 3'd0 || ifa.Pc_in !== 32'd0 || ifa.Pc_out !== 32'd0) begin
      nerr++; $display("FAIL mid_reset_state: got lines %0d pc_in %h pc_out %h expected 0 0 0", ifa.Lines_used, ifa.Pc_in, ifa.Pc_out);
    end
    release_reset();
    inject = 1'b1;
    cyc(1'b0, 1'b0, 32'd0);
    inject = 1'b0;
    nvec++; if (ifa.Empty !== 1'b1) begin nerr++; $display("FAIL late_resp_bypass: got %b expected 1", ifa.Empty); end
    cyc(1'b0, 1'b0, 32'd0);
    nvec++; if (ifa.Lines_used !== 3'd0) begin nerr++; $display("FAIL late_resp_written: got %0d expected 0", ifa.Lines_used); end
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 32'd0);
  endtask

  task automatic test_random();
    int p0;
    logic jv;
    assert_reset(); release_reset();
    p0 = npop;
    for (int i = 0; i < 400; i++) begin
      lat = int'($urandom_range(0, 3));
      jv = ($urandom_range(0, 29) == 0);
      cyc(($urandom_range(0, 3) != 0), jv, $urandom);
    end
    nvec++; if (npop - p0 < 100) begin nerr++; $display("FAIL random_progress: got %0d pops expected >=100", npop - p0); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_stream();
    test_full();
    test_jump_pending();
    test_jump_resp();
    test_bypass_latency();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
